direction_filter: RTL and testbench
===================================

Name: direction_filter

Overview:
- Sits directly upstream of game_logic. It replaces the raw joystick path that feeds `direction`.
- It does the following, in order:
  - synchronises the four joystick comparator inputs;
  - debounces the 4-bit input pattern;
  - decodes it into a one-hot direction request;
  - holds the latest request until the next game update strike.
- On each update strike it commits the pending direction to game_logic, unless the request is a 180° reversal of the current heading.

Parameters:
- DEBOUNCE_CYCLES, 125000, consecutive clk cycles a pattern must be stable before it is accepted (5 ms at 25 MHz).
- CNT_W, 17, width of the debounce counter; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.
- INIT_DIR, 2'b01, heading loaded at reset (RIGHT).

Ports:
- clk  input  1  VGA pixel clock (25 MHz); every register is on its rising edge.
- reset  input  1  asynchronous, active-low; clears all state.
- res_x_one  input  1  asynchronous comparator; 1 = stick pushed RIGHT.
- res_x_two  input  1  asynchronous comparator; 1 = stick pushed LEFT.
- res_y_one  input  1  asynchronous comparator; 1 = stick pushed UP.
- res_y_two  input  1  asynchronous comparator; 1 = stick pushed DOWN.
- upd_tick  input  1  single-cycle strobe, one per game update, synchronous to clk.
- direction  output  [0:1]  committed heading: 00 UP, 01 RIGHT, 10 DOWN, 11 LEFT.
- req_pending  output  1  a valid request is waiting for the next upd_tick.
- rev_reject  output  1  one-cycle pulse when a reversal request is discarded on upd_tick.

Behaviour:

Reset (reset = 0, asynchronous):
- Synchroniser flops, stable pattern and counter cleared to 0.
- pending cleared; req_pending = 0; rev_reject = 0; direction = INIT_DIR.

Synchroniser:
- Two flops per input; the raw pattern p = {up, right, down, left} is taken after the second flop.
- Latency from input pin to p is 2 cycles.

Debouncer:
- Holds a stable pattern s and a counter cnt.
- If p != the last sampled p: cnt ← 0.
- Else if cnt == DEBOUNCE_CYCLES-1: s ← p and an accept strobe fires for one cycle. cnt stays saturated, so accept fires once per stable pattern.
- Else: cnt ← cnt+1.
- Minimum latency from an input change to accept is 2 + DEBOUNCE_CYCLES cycles.

Decode (on accept):
- Exactly one bit of s set → request r (UP 00, RIGHT 01, DOWN 10, LEFT 11), marked valid.
- Zero bits set (stick centred) → no request; pending is left unchanged.
- Two or more bits set (diagonal or fault) → no request; pending is left unchanged.

Pending register:
- A valid decode overwrites pending and sets req_pending = 1. The newest request wins.

Commit (on upd_tick = 1):
- If req_pending = 0: direction is unchanged.
- If req_pending = 1 and pending == direction ^ 2'b10 (reversal): direction is unchanged and rev_reject = 1 next cycle.
- Otherwise: direction ← pending, effective the next cycle.
- req_pending is cleared in both of the last two cases.

Simultaneous accept and upd_tick in the same cycle:
- The commit uses the old pending value.
- The new request is written to pending and req_pending stays 1; the write wins over the clear.

Other rules:
- upd_tick held high on consecutive cycles: each cycle is treated as a separate tick.
- direction changes only in the cycle after an upd_tick, never otherwise.
- Reset asserted mid-debounce or with a request pending: all state discarded; direction = INIT_DIR immediately, without waiting for a clock.

Test Plan (DEBOUNCE_CYCLES = 8 for simulation):
1. Reset release, no stick input, upd_tick every 20 cycles → direction stays 01 and req_pending stays 0 indefinitely.
2. res_y_one held 1 for 12 cycles, then upd_tick → req_pending rises at cycle 10 (2 + 8) after the input edge; direction becomes 00 the cycle after the tick; req_pending drops.
3. Heading 01; res_x_two (LEFT) held stable, then upd_tick → direction stays 01, rev_reject pulses for exactly one cycle, req_pending = 0.
4. res_y_two toggled every 5 cycles for 100 cycles → no accept and req_pending = 0. Then held 1 for 10 cycles → request DOWN becomes pending.
5. res_y_one and res_x_one both held 1 → no request. Then UP stable, then DOWN stable, both before a tick → the tick commits 10 (latest request wins).
6. Request pending, reset pulsed low for 3 ns between clock edges → direction = 01 and req_pending = 0 asynchronously; the following tick changes nothing.

Source files
------------

// File: rtl/direction_filter.sv
// rtl/direction_filter.sv - joystick synchroniser, debouncer, decoder and tick-aligned heading commit
module direction_filter #(
   parameter int         DEBOUNCE_CYCLES = 125000,
   parameter int         CNT_W           = 17,
   parameter logic [1:0] INIT_DIR        = 2'b01
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       res_x_one,
   input  logic       res_x_two,
   input  logic       res_y_one,
   input  logic       res_y_two,
   input  logic       upd_tick,
   output logic [0:1] direction,
   output logic       req_pending,
   output logic       rev_reject
);

   // Counter stops one past the accept value so accept fires once per stable pattern
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(DEBOUNCE_CYCLES);

   logic [3:0]       sync1;
   logic [3:0]       p;
   logic [CNT_W-1:0] cnt;
   logic             accept;
   logic [1:0]       req;
   logic             req_valid;
   logic [1:0]       pending;
   logic [1:0]       dir_q;

   // Two-flop synchroniser; pattern order is {up, right, down, left}
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync1 <= 4'b0000;
         p     <= 4'b0000;
      end else begin
         sync1 <= {res_y_one, res_x_one, res_y_two, res_x_two};
         p     <= sync1;
      end
   end

   // A new sample differing from p restarts the count; the pattern is accepted
   // on the cycle the count reaches DEBOUNCE_CYCLES-1, giving 2+DEBOUNCE_CYCLES latency
   assign accept = (sync1 == p) && (cnt == CNT_LAST);

   // Debounce counter, saturating after the accept cycle
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt <= '0;
      end else if (sync1 != p) begin
         cnt <= '0;
      end else if (cnt == CNT_LAST) begin
         cnt <= CNT_SAT;
      end else if (cnt != CNT_SAT) begin
         cnt <= cnt + 1'b1;
      end
   end

   // One-hot decode of the accepted pattern; centred or diagonal yields no request
   always_comb begin
      req       = 2'b00;
      req_valid = 1'b0;
      unique case (p)
         4'b1000: begin req = 2'b00; req_valid = 1'b1; end
         4'b0100: begin req = 2'b01; req_valid = 1'b1; end
         4'b0010: begin req = 2'b10; req_valid = 1'b1; end
         4'b0001: begin req = 2'b11; req_valid = 1'b1; end
         default: begin req = 2'b00; req_valid = 1'b0; end
      endcase
   end

   // Commit on tick unless reversal; a fresh request in the same cycle overrides the clear
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pending     <= 2'b00;
         req_pending <= 1'b0;
         rev_reject  <= 1'b0;
         dir_q       <= INIT_DIR;
      end else begin
         rev_reject <= 1'b0;
         if (upd_tick && req_pending) begin
            req_pending <= 1'b0;
            if (pending == (dir_q ^ 2'b10)) begin
               rev_reject <= 1'b1;
            end else begin
               dir_q <= pending;
            end
         end
         if (accept && req_valid) begin
            pending     <= req;
            req_pending <= 1'b1;
         end
      end
   end

   assign direction = dir_q;

endmodule

// File: tb/tb_direction_filter.sv
// tb/tb_direction_filter.sv - directed self-checking bench for direction_filter
module tb_direction_filter;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       res_x_one = 1'b0;
   logic       res_x_two = 1'b0;
   logic       res_y_one = 1'b0;
   logic       res_y_two = 1'b0;
   logic       upd_tick = 1'b0;
   logic [0:1] direction;
   logic       req_pending;
   logic       rev_reject;

   int n_checks = 0;
   int n_errors = 0;

   direction_filter #(
      .DEBOUNCE_CYCLES(8),
      .CNT_W(4),
      .INIT_DIR(2'b01)
   ) dut (
      .clk(clk),
      .reset(reset),
      .res_x_one(res_x_one),
      .res_x_two(res_x_two),
      .res_y_one(res_y_one),
      .res_y_two(res_y_two),
      .upd_tick(upd_tick),
      .direction(direction),
      .req_pending(req_pending),
      .rev_reject(rev_reject)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic pulse_tick();
      upd_tick = 1'b1;
      cyc(1);
      upd_tick = 1'b0;
   endtask

   initial begin
      // Reset state
      cyc(2);
      check("rst_dir", 32'(direction), 32'h1);
      check("rst_pend", 32'(req_pending), 32'h0);
      check("rst_rej", 32'(rev_reject), 32'h0);
      reset = 1'b1;

      // 1: idle stick, periodic ticks
      for (int i = 0; i < 3; i++) begin
         cyc(19);
         pulse_tick();
         check("idle_dir", 32'(direction), 32'h1);
         check("idle_pend", 32'(req_pending), 32'h0);
      end

      // 2: UP, latency 2+8 cycles
      res_y_one = 1'b1;
      cyc(9);
      check("up_lat9", 32'(req_pending), 32'h0);
      cyc(1);
      check("up_lat10", 32'(req_pending), 32'h1);
      cyc(2);
      res_y_one = 1'b0;
      check("up_hold_dir", 32'(direction), 32'h1);
      pulse_tick();
      check("up_dir", 32'(direction), 32'h0);
      check("up_pend", 32'(req_pending), 32'h0);
      cyc(15);

      // 3: back to RIGHT, then LEFT is a reversal
      res_x_one = 1'b1;
      cyc(12);
      res_x_one = 1'b0;
      pulse_tick();
      check("right_dir", 32'(direction), 32'h1);
      cyc(15);
      res_x_two = 1'b1;
      cyc(12);
      res_x_two = 1'b0;
      check("left_pend", 32'(req_pending), 32'h1);
      pulse_tick();
      check("rev_dir", 32'(direction), 32'h1);
      check("rev_pulse", 32'(rev_reject), 32'h1);
      check("rev_pend", 32'(req_pending), 32'h0);
      cyc(1);
      check("rev_pulse_end", 32'(rev_reject), 32'h0);
      cyc(15);

      // 4: bouncing DOWN never accepted, then stable DOWN
      for (int i = 0; i < 20; i++) begin
         res_y_two = ~res_y_two;
         cyc(5);
      end
      check("bounce_pend", 32'(req_pending), 32'h0);
      res_y_two = 1'b1;
      cyc(10);
      check("down_pend", 32'(req_pending), 32'h1);
      res_y_two = 1'b0;
      pulse_tick();
      check("down_dir", 32'(direction), 32'h2);
      cyc(15);

      // 5: diagonal ignored; UP (a reversal) then LEFT, newest wins
      res_y_one = 1'b1;
      res_x_one = 1'b1;
      cyc(12);
      check("diag_pend", 32'(req_pending), 32'h0);
      res_y_one = 1'b0;
      res_x_one = 1'b0;
      cyc(15);
      res_y_one = 1'b1;
      cyc(12);
      res_y_one = 1'b0;
      cyc(15);
      res_x_two = 1'b1;
      cyc(12);
      res_x_two = 1'b0;
      cyc(15);
      pulse_tick();
      check("latest_dir", 32'(direction), 32'h3);
      check("latest_rej", 32'(rev_reject), 32'h0);
      cyc(15);

      // 6: asynchronous reset with a request pending
      res_y_one = 1'b1;
      cyc(12);
      res_y_one = 1'b0;
      check("pre_rst_pend", 32'(req_pending), 32'h1);
      #1;
      reset = 1'b0;
      #1;
      check("arst_dir", 32'(direction), 32'h1);
      check("arst_pend", 32'(req_pending), 32'h0);
      #2;
      reset = 1'b1;
      cyc(2);
      pulse_tick();
      check("post_rst_dir", 32'(direction), 32'h1);
      check("post_rst_pend", 32'(req_pending), 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
